// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and
// the control FSM encoding. The optional sequential multiplier is enabled by
// defining the macro ALU_MUL_EN; without it the FSM has only the IDLE state.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL = 4'd8;

    // Positions inside the 4-bit {Z,N,C,V} flag vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

`ifdef ALU_MUL_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;
`else
    typedef enum logic {
        ST_IDLE = 1'b0
    } state_e;
`endif

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-side and result-side valid/ready handshake of the pipelined ALU.
// master = producer of operands / consumer of results, slave = the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 2
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_err, out_tag
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle. Bit 0 is
// consumed on the start edge, the remaining WIDTH-1 bits on the following
// edges; done is then high for one cycle with the full product on 'product'.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                busy_q,   busy_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]  acc_q,    acc_d;
    logic [2*WIDTH-1:0]  mcand_q,  mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;

    // Next-state: load operands on start, then add/shift until the count runs out.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_d = b >> 1;
            cnt_d    = CNT_W'(WIDTH - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
            end
        end
    end

    // State registers, synchronously cleared so a reset aborts any product in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops load the
// result register on the accept edge. With ALU_MUL_EN defined, opcode 8 runs
// through alu_mul_seq while the FSM sits in BUSY; otherwise opcode 8 is illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TAG_W = 2
) (
    input  logic     clk,
    input  logic     rst,
    alu_pipe_if.slave bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_e             state_q,     state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic [3:0]         flags_q,     flags_d;
    logic               err_q,       err_d;
    logic [TAG_W-1:0]   tag_q,       tag_d;

    logic               in_ready;
    logic               accept;
    logic               start_mul;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   calc_result;
    logic [3:0]         calc_flags;
    logic               calc_err;
    logic               calc_c;
    logic               calc_v;

    // Only accept when idle and the result register is empty or draining now.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign start_mul = accept && (bus.in_op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_mul),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign start_mul = 1'b0;
`endif

    // Single-cycle datapath: op mux plus Z/N/C/V; illegal opcodes give result 0, err 1.
    always_comb begin
        sum         = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        diff        = bus.in_a - bus.in_b;
        shamt       = bus.in_b[SH_W-1:0];
        calc_result = '0;
        calc_c      = 1'b0;
        calc_v      = 1'b0;
        calc_err    = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                calc_result = sum[WIDTH-1:0];
                calc_c      = sum[WIDTH];
                calc_v      = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SUB: begin
                calc_result = diff;
                calc_c      = bus.in_a < bus.in_b;
                calc_v      = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                              (diff[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_AND:  calc_result = bus.in_a & bus.in_b;
            OP_OR:   calc_result = bus.in_a | bus.in_b;
            OP_XOR:  calc_result = bus.in_a ^ bus.in_b;
            OP_SLL:  calc_result = bus.in_a << shamt;
            OP_SRL:  calc_result = bus.in_a >> shamt;
            OP_SLT:  calc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
`ifdef ALU_MUL_EN
            OP_MUL:  calc_result = '0;
`endif
            default: calc_err = 1'b1;
        endcase
        calc_flags         = '0;
        calc_flags[FLAG_Z] = (calc_result == '0);
        calc_flags[FLAG_N] = calc_result[WIDTH-1];
        calc_flags[FLAG_C] = calc_c;
        calc_flags[FLAG_V] = calc_v;
    end

    // Control and result-register next state: drain, accept, multiplier completion.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        err_d       = err_q;
        tag_d       = tag_q;
`ifdef ALU_MUL_EN
        pend_tag_d  = pend_tag_q;
`endif
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (start_mul) begin
`ifdef ALU_MUL_EN
                state_d    = ST_BUSY;
                pend_tag_d = bus.in_tag;
`endif
            end else begin
                out_valid_d = 1'b1;
                result_d    = calc_result;
                flags_d     = calc_flags;
                err_d       = calc_err;
                tag_d       = bus.in_tag;
            end
        end
`ifdef ALU_MUL_EN
        if ((state_q == ST_BUSY) && mul_done) begin
            state_d         = ST_IDLE;
            out_valid_d     = 1'b1;
            result_d        = mul_product[WIDTH-1:0];
            flags_d         = '0;
            flags_d[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
            flags_d[FLAG_N] = mul_product[WIDTH-1];
            flags_d[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
            err_d           = 1'b0;
            tag_d           = pend_tag_q;
        end
`endif
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            tag_q       <= '0;
`ifdef ALU_MUL_EN
            pend_tag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
`ifdef ALU_MUL_EN
            pend_tag_q  <= pend_tag_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_flags  = flags_q;
    assign bus.out_err    = err_q;
    assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=4, TAG_W=2): directed vector table,
// backpressure sequence, random stream against a reference model, and the
// multiplier or illegal-opcode-8 cases depending on ALU_MUL_EN.
module tb_alu_pipe;

    localparam int W    = 4;
    localparam int TW   = 2;
    localparam int FULL = 16;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic [3:0]    flags;
        logic          err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(logic v, logic e, logic [3:0] fl, logic [TW-1:0] t, logic [W-1:0] r);
        return {20'd0, v, e, fl, t, r};
    endfunction

    function automatic logic [31:0] pack_out();
        return pk(bus.out_valid, bus.out_err, bus.out_flags, bus.out_tag, bus.out_result);
    endfunction

    function automatic vec_t mk(int op, int a, int b, int tag, int res, logic [3:0] fl, logic e);
        vec_t v;
        v.op = 4'(op); v.a = W'(a); v.b = W'(b); v.tag = TW'(tag);
        v.res = W'(res); v.flags = fl; v.err = e;
        return v;
    endfunction

    // Reference model: integer arithmetic on the opcode definitions.
    function automatic vec_t ref_alu(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [TW-1:0] tag);
        vec_t v;
        int ia, ib, sa, sb, r, sh;
        bit c, ov, e;
        ia = int'(a); ib = int'(b);
        sa = (ia >= HALF) ? ia - FULL : ia;
        sb = (ib >= HALF) ? ib - FULL : ib;
        sh = ib % W;
        r = 0; c = 0; ov = 0; e = 0;
        case (int'(op))
            0: begin r = ia + ib; c = (r >= FULL); ov = ((sa + sb) >= HALF) || ((sa + sb) < -HALF); end
            1: begin r = ia - ib; c = (ia < ib);   ov = ((sa - sb) >= HALF) || ((sa - sb) < -HALF); end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = ia ^ ib;
            5: r = ia << sh;
            6: r = ia >> sh;
            7: r = (sa < sb) ? 1 : 0;
`ifdef ALU_MUL_EN
            8: begin r = ia * ib; c = (r >= FULL); end
`endif
            default: e = 1;
        endcase
        r = ((r % FULL) + FULL) % FULL;
        v.op = op; v.a = a; v.b = b; v.tag = tag;
        v.res = W'(r); v.err = e;
        v.flags = {(r == 0), (r >= HALF), c, ov};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_op  = v.op;
        bus.in_a   = v.a;
        bus.in_b   = v.b;
        bus.in_tag = v.tag;
    endtask

    // One beat with out_ready high; the result must be visible right after the accept edge.
    task automatic run_vec(input vec_t v, input string name);
        int n;
        drive(v);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check(name, pack_out(), pk(1'b1, v.err, v.flags, v.tag, v.res));
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_case(input int a, input int b, input int tag, input int res,
                            input logic [3:0] fl, input string name);
        int bad;
        drive(mk(8, a, b, tag, 0, 4'b0000, 1'b0));
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({name, "_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < W; k++) begin
            if (bus.in_ready || bus.out_valid) bad++;
            step();
        end
        check({name, "_busy"}, 32'(bad), 32'd0);
        check(name, pack_out(), pk(1'b1, 1'b0, fl, TW'(tag), W'(res)));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t exp_q[$];
        vec_t cur;
        vec_t e;
        int   bad, sent, got;
        bit   acc, xfer;

        // Directed vectors: {op, a, b, tag, result, {Z,N,C,V}, err}
        tbl.push_back(mk(0,  2,  5, 1,  7, 4'b0000, 1'b0));
        tbl.push_back(mk(1,  2,  5, 2, 13, 4'b0110, 1'b0));
        tbl.push_back(mk(0,  7,  1, 3,  8, 4'b0101, 1'b0));
        tbl.push_back(mk(1,  5,  5, 0,  0, 4'b1000, 1'b0));
        tbl.push_back(mk(7, 12,  2, 1,  1, 4'b0000, 1'b0));
        tbl.push_back(mk(6, 12,  2, 2,  3, 4'b0000, 1'b0));
        tbl.push_back(mk(5,  3,  3, 3,  8, 4'b0100, 1'b0));
        tbl.push_back(mk(2, 12, 10, 0,  8, 4'b0100, 1'b0));
        tbl.push_back(mk(3,  0,  0, 1,  0, 4'b1000, 1'b0));
        tbl.push_back(mk(4, 15,  5, 2, 10, 4'b0100, 1'b0));
        tbl.push_back(mk(0, 15,  1, 3,  0, 4'b1010, 1'b0));
        tbl.push_back(mk(1,  8,  1, 0,  7, 4'b0001, 1'b0));
        tbl.push_back(mk(7,  2, 12, 1,  0, 4'b1000, 1'b0));
        tbl.push_back(mk(9,  3,  4, 2,  0, 4'b1000, 1'b1));
        tbl.push_back(mk(15,15, 15, 3,  0, 4'b1000, 1'b1));
`ifndef ALU_MUL_EN
        tbl.push_back(mk(8,  3,  5, 1,  0, 4'b1000, 1'b1));
`endif

        // Reset state
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_tag = '0;
        step(); step();
        check("reset_out", pack_out(), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        step();

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));
        step();

        // Backpressure: first result held while out_ready=0, second beat waits.
        bus.out_ready = 1'b0;
        drive(mk(0, 1, 1, 2, 0, 4'b0000, 1'b0));
        bus.in_valid = 1'b1;
        step();
        check("bp_first", pack_out(), pk(1'b1, 1'b0, 4'b0000, 2'd2, 4'd2));
        drive(mk(4, 3, 5, 3, 0, 4'b0000, 1'b0));
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.in_ready) bad++;
            if (pack_out() !== pk(1'b1, 1'b0, 4'b0000, 2'd2, 4'd2)) bad++;
            step();
        end
        check("bp_hold", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_second", pack_out(), pk(1'b1, 1'b0, 4'b0000, 2'd3, 4'd6));
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Random stream against the reference model with random backpressure.
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
            if (!bus.in_valid && sent < 8 && ($urandom % 4) != 0) begin
                cur = ref_alu(4'($urandom_range(0, 10)), W'($urandom_range(0, 15)),
                              W'($urandom_range(0, 15)), TW'($urandom_range(0, 3)));
                drive(cur);
                bus.in_valid = 1'b1;
            end
            bus.out_ready = 1'($urandom % 2);
            @(negedge clk);
            acc  = bus.in_valid && bus.in_ready;
            xfer = bus.out_valid && bus.out_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", pack_out(), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("stream%0d", got), pack_out(), pk(1'b1, e.err, e.flags, e.tag, e.res));
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(cur);
                sent++;
            end
            step();
            if (acc) bus.in_valid = 1'b0;
        end
        check("stream_count", 32'(got), 32'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.out_valid) bad++;
        end
        check("stream_no_dup", 32'(bad + exp_q.size()), 32'd0);

`ifdef ALU_MUL_EN
        mul_case(3, 5, 2, 15, 4'b0100, "mul_3x5");
        step();
        mul_case(15, 15, 1, 1, 4'b0010, "mul_15x15");
        step();
        // Reset while the multiplier is running must drop the operation.
        drive(mk(8, 7, 7, 3, 0, 4'b0000, 1'b0));
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) bad++;
            step();
        end
        check("rst_busy_no_out", 32'(bad), 32'd0);
        check("rst_busy_ready", 32'(bus.in_ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
